// File: rtl/ehl_debounce.sv
// Digital debounce filter: dout follows din only after din has differed from
// dout on FILTER_LEN consecutive enabled clock edges, with edge pulses on change.
module ehl_debounce #(
   parameter int unsigned FILTER_LEN = 4,
   parameter bit          INIT_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   input  logic en,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   // state     | meaning
   // STABLE_LO | dout=0, din agrees, counter idle
   // CHECK_HI  | dout=0, din=1 being qualified
   // STABLE_HI | dout=1, din agrees, counter idle
   // CHECK_LO  | dout=1, din=0 being qualified
   // Encoding puts dout on bit 1 and busy on bit 0 so both come straight off flops.
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      CHECK_HI  = 2'b01,
      STABLE_HI = 2'b10,
      CHECK_LO  = 2'b11
   } state_t;

   localparam int unsigned       CNT_W      = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FILTER_LEN);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam bit                SINGLE     = (FILTER_LEN == 1);
   localparam state_t            STATE_INIT = INIT_VAL ? STABLE_HI : STABLE_LO;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_rise;
   logic             r_fall;
   logic             w_rise_nxt;
   logic             w_fall_nxt;

   assign w_cnt_inc = r_cnt + CNT_ONE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= STATE_INIT;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (en) begin
         case (r_state)
            STABLE_LO: begin
               if (din) begin
                  if (SINGLE) begin
                     w_state_nxt = STABLE_HI;
                     w_rise_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = CHECK_HI;
                     w_cnt_nxt   = CNT_ONE;
                  end
               end
            end
            CHECK_HI: begin
               if (!din) begin
                  w_state_nxt = STABLE_LO;
                  w_cnt_nxt   = '0;
               end else if (w_cnt_inc == CNT_FULL) begin
                  w_state_nxt = STABLE_HI;
                  w_cnt_nxt   = '0;
                  w_rise_nxt  = 1'b1;
               end else if (r_cnt != CNT_FULL) begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            STABLE_HI: begin
               if (!din) begin
                  if (SINGLE) begin
                     w_state_nxt = STABLE_LO;
                     w_fall_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = CHECK_LO;
                     w_cnt_nxt   = CNT_ONE;
                  end
               end
            end
            CHECK_LO: begin
               if (din) begin
                  w_state_nxt = STABLE_HI;
                  w_cnt_nxt   = '0;
               end else if (w_cnt_inc == CNT_FULL) begin
                  w_state_nxt = STABLE_LO;
                  w_cnt_nxt   = '0;
                  w_fall_nxt  = 1'b1;
               end else if (r_cnt != CNT_FULL) begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            default: begin
               w_state_nxt = STATE_INIT;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign dout = r_state[1];
   assign busy = r_state[0];
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: tb/tb_ehl_debounce.sv
// Bench for ehl_debounce: FILTER_LEN=4/INIT_VAL=0 instance driven with directed
// scenarios, plus a FILTER_LEN=1/INIT_VAL=1 instance fed a fixed bit pattern.
module tb_ehl_debounce;

   logic clk;
   logic rst_n;
   logic din_a, en_a, dout_a, rise_a, fall_a, busy_a;
   logic din_b, dout_b, rise_b, fall_b, busy_b;
   logic en_b;

   int n_checks = 0;
   int n_pass   = 0;

   ehl_debounce #(.FILTER_LEN(4), .INIT_VAL(1'b0)) u_dut_a (
      .clk     (clk),
      .reset_n (rst_n),
      .din     (din_a),
      .en      (en_a),
      .dout    (dout_a),
      .rise    (rise_a),
      .fall    (fall_a),
      .busy    (busy_a)
   );

   ehl_debounce #(.FILTER_LEN(1), .INIT_VAL(1'b1)) u_dut_b (
      .clk     (clk),
      .reset_n (rst_n),
      .din     (din_b),
      .en      (en_b),
      .dout    (dout_b),
      .rise    (rise_b),
      .fall    (fall_b),
      .busy    (busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model A: length of the current run of enabled samples disagreeing with dout.
   int   m_run;
   logic m_dout, m_rise, m_fall;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  <= 0;
         m_dout <= 1'b0;
         m_rise <= 1'b0;
         m_fall <= 1'b0;
      end else begin
         m_rise <= 1'b0;
         m_fall <= 1'b0;
         if (en_a) begin
            if (din_a != m_dout) begin
               if (m_run + 1 == 4) begin
                  m_dout <= din_a;
                  m_run  <= 0;
                  if (din_a) m_rise <= 1'b1;
                  else       m_fall <= 1'b1;
               end else begin
                  m_run <= m_run + 1;
               end
            end else begin
               m_run <= 0;
            end
         end
      end
   end

   // Model B: with a one-cycle filter, dout is simply din one edge late.
   logic m_prev, m_prev2;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev  <= 1'b1;
         m_prev2 <= 1'b1;
      end else begin
         m_prev  <= din_b;
         m_prev2 <= m_prev;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("a_dout", dout_a, m_dout);
         chk("a_rise", rise_a, m_rise);
         chk("a_fall", fall_a, m_fall);
         chk("a_busy", busy_a, m_run != 0);
         chk("b_dout", dout_b, m_prev);
         chk("b_rise", rise_b, m_prev & ~m_prev2);
         chk("b_fall", fall_b, ~m_prev & m_prev2);
         chk("b_busy", busy_b, 1'b0);
      end
   end

   logic [15:0] pat_b;
   initial begin
      pat_b = 16'b0110_1000_1110_0101;
      en_b  = 1'b1;
      din_b = 1'b0;
      for (int i = 0; ; i++) begin
         @(negedge clk);
         din_b = pat_b[i % 16];
      end
   end

   initial begin
      rst_n = 1'b0;
      din_a = 1'b1;
      en_a  = 1'b1;

      // reset with din=1 held
      tick(3);
      chk("rst_dout", dout_a, 1'b0);
      chk("rst_rise", rise_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_b_dout", dout_b, 1'b1);
      rst_n = 1'b1;
      tick(1);
      chk("q1_busy", busy_a, 1'b1);
      tick(2);
      chk("q3_dout", dout_a, 1'b0);
      tick(1);
      chk("q4_dout", dout_a, 1'b1);
      chk("q4_rise", rise_a, 1'b1);
      chk("q4_busy", busy_a, 1'b0);
      tick(1);
      chk("q5_rise", rise_a, 1'b0);

      // clean fall, then a clean rise/fall pair 10 cycles apart
      din_a = 1'b0;
      tick(3);
      chk("f3_dout", dout_a, 1'b1);
      tick(1);
      chk("f4_dout", dout_a, 1'b0);
      chk("f4_fall", fall_a, 1'b1);
      tick(1);
      din_a = 1'b1;
      tick(10);
      chk("step_hi", dout_a, 1'b1);
      din_a = 1'b0;
      tick(10);
      chk("step_lo", dout_a, 1'b0);

      // glitches of 1..3 cycles never reach dout
      for (int len = 1; len <= 3; len++) begin
         din_a = 1'b1;
         tick(len);
         chk("glitch_busy", busy_a, 1'b1);
         din_a = 1'b0;
         tick(5);
      end
      chk("glitch_dout", dout_a, 1'b0);

      // enable dropped after two qualifying edges
      din_a = 1'b1;
      tick(2);
      en_a = 1'b0;
      tick(5);
      chk("hold_busy", busy_a, 1'b1);
      chk("hold_dout", dout_a, 1'b0);
      en_a = 1'b1;
      tick(1);
      chk("res3_dout", dout_a, 1'b0);
      tick(1);
      chk("res4_dout", dout_a, 1'b1);
      chk("res4_rise", rise_a, 1'b1);
      din_a = 1'b0;
      tick(6);

      // reset in the middle of qualification
      din_a = 1'b1;
      tick(2);
      chk("pre_busy", busy_a, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_dout", dout_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      chk("rq1_busy", busy_a, 1'b1);
      tick(2);
      chk("rq3_dout", dout_a, 1'b0);
      tick(1);
      chk("rq4_dout", dout_a, 1'b1);
      chk("rq4_rise", rise_a, 1'b1);
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
